// File: rtl/mig_jtag_tap.sv
// JTAG TAP responder: oversamples tck/tms/tdi/trstn in the clk domain and runs the 1149.1 FSM.
// Optional feature macro MIG_JTAG_USER_DR_EN adds the 32-bit user DR selected by IR 0x10.
module mig_jtag_tap #(
  parameter int unsigned IR_WIDTH   = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_563D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  input  logic        trstn,
  output logic        tdo,
  input  logic [31:0] dr_capture_data,
  output logic [31:0] dr_update_data,
  output logic        dr_update_valid,
  output logic [3:0]  tap_state
);

  typedef enum logic [3:0] {
    StExit2Dr = 4'h0, StExit1Dr = 4'h1, StShiftDr = 4'h2, StPauseDr = 4'h3,
    StSelIr   = 4'h4, StUpdDr   = 4'h5, StCapDr   = 4'h6, StSelDr   = 4'h7,
    StExit2Ir = 4'h8, StExit1Ir = 4'h9, StShiftIr = 4'hA, StPauseIr = 4'hB,
    StRti     = 4'hC, StUpdIr   = 4'hD, StCapIr   = 4'hE, StTlr     = 4'hF
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(1);

  logic [2:0] tck_q;
  logic [1:0] tms_q, tdi_q, trstn_q;
  logic       tck_rise, tck_fall, tms_s, tdi_s, trst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_q   <= '0;
      tms_q   <= '0;
      tdi_q   <= '0;
      trstn_q <= 2'b11;
    end else begin
      tck_q   <= {tck_q[1:0], tck};
      tms_q   <= {tms_q[0], tms};
      tdi_q   <= {tdi_q[0], tdi};
      trstn_q <= {trstn_q[0], trstn};
    end
  end

  // tck_q[1] is the synchronized level, tck_q[2] the previous sample.
  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];
  assign trst     = ~trstn_q[1];

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
  logic [31:0]         id_sr_q;
  logic                byp_q;
  logic                sel_id, sel_user, dr_lsb;

  assign sel_id    = (ir_q == IrIdcode);
  assign tap_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StTlr:     state_d = tms_s ? StTlr     : StRti;
      StRti:     state_d = tms_s ? StSelDr   : StRti;
      StSelDr:   state_d = tms_s ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms_s ? StExit1Dr : StShiftDr;
      StShiftDr: state_d = tms_s ? StExit1Dr : StShiftDr;
      StExit1Dr: state_d = tms_s ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms_s ? StExit2Dr : StPauseDr;
      StExit2Dr: state_d = tms_s ? StUpdDr   : StShiftDr;
      StUpdDr:   state_d = tms_s ? StSelDr   : StRti;
      StSelIr:   state_d = tms_s ? StTlr     : StCapIr;
      StCapIr:   state_d = tms_s ? StExit1Ir : StShiftIr;
      StShiftIr: state_d = tms_s ? StExit1Ir : StShiftIr;
      StExit1Ir: state_d = tms_s ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms_s ? StExit2Ir : StPauseIr;
      StExit2Ir: state_d = tms_s ? StUpdIr   : StShiftIr;
      StUpdIr:   state_d = tms_s ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

`ifdef MIG_JTAG_USER_DR_EN
  localparam logic [IR_WIDTH-1:0] IrUser = IR_WIDTH'(5'h10);

  logic [31:0] user_sr_q;

  assign sel_user = (ir_q == IrUser);
  assign dr_lsb   = sel_id ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_q);

  // A test reset suppresses any tck edge, so an aborted shift never reaches update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_sr_q       <= '0;
      dr_update_data  <= '0;
      dr_update_valid <= 1'b0;
    end else begin
      dr_update_valid <= 1'b0;
      if (!trst && sel_user) begin
        if (tck_rise && state_q == StCapDr) begin
          user_sr_q <= dr_capture_data;
        end else if (tck_rise && state_q == StShiftDr) begin
          user_sr_q <= {tdi_s, user_sr_q[31:1]};
        end else if (tck_fall && state_q == StUpdDr) begin
          dr_update_data  <= user_sr_q;
          dr_update_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_capture;

  assign sel_user        = 1'b0;
  assign dr_lsb          = sel_id ? id_sr_q[0] : byp_q;
  assign dr_update_data  = '0;
  assign dr_update_valid = 1'b0;
  assign unused_capture  = ^dr_capture_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StTlr;
      ir_q    <= IrIdcode;
      ir_sr_q <= '0;
      id_sr_q <= '0;
      byp_q   <= 1'b0;
      tdo     <= 1'b0;
    end else if (trst) begin
      state_q <= StTlr;
      ir_q    <= IrIdcode;
    end else if (tck_rise) begin
      state_q <= state_d;
      if (state_d == StTlr) ir_q <= IrIdcode;
      case (state_q)
        StCapIr:   ir_sr_q <= IrIdcode;  // capture pattern 0..01
        StShiftIr: ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
        StCapDr: begin
          if (sel_id)         id_sr_q <= IDCODE_VAL;
          else if (!sel_user) byp_q   <= 1'b0;
        end
        StShiftDr: begin
          if (sel_id)         id_sr_q <= {tdi_s, id_sr_q[31:1]};
          else if (!sel_user) byp_q   <= tdi_s;
        end
        default: ;
      endcase
    end else if (tck_fall) begin
      if (state_q == StUpdIr) ir_q <= ir_sr_q;
      if (state_q == StShiftIr)      tdo <= ir_sr_q[0];
      else if (state_q == StShiftDr) tdo <= dr_lsb;
      else                           tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mig_jtag_tap.sv
// Scoreboard bench for mig_jtag_tap: a transaction-level TAP model predicts tdo per tck rise and
// every user-DR update; monitors pop and compare as the DUT presents them.
module tb_mig_jtag_tap;

  localparam int PH = 6;  // clk cycles per tck phase
  localparam logic [31:0] IDCODE = 32'h1000_563D;
`ifdef MIG_JTAG_USER_DR_EN
  localparam bit UserEn = 1'b1;
`else
  localparam bit UserEn = 1'b0;
`endif

  // Next-state table from the standard TAP diagram, indexed by state code: {tms=1, tms=0}.
  localparam bit [7:0] NEXT [16] = '{
    8'h52, 8'h53, 8'h12, 8'h03, 8'hFE, 8'h7C, 8'h12, 8'h46,
    8'hDA, 8'hDB, 8'h9A, 8'h8B, 8'h7C, 8'h7C, 8'h9A, 8'hFC
  };

  logic        clk = 1'b0, rst = 1'b1, tck = 1'b0, tms = 1'b0, tdi = 1'b0, trstn = 1'b1;
  logic        tdo, dr_update_valid;
  logic [31:0] dr_capture_data = '0, dr_update_data;
  logic [3:0]  tap_state;

  always #5 clk = ~clk;

  mig_jtag_tap dut (
    .clk             (clk),
    .rst             (rst),
    .tck             (tck),
    .tms             (tms),
    .tdi             (tdi),
    .trstn           (trstn),
    .tdo             (tdo),
    .dr_capture_data (dr_capture_data),
    .dr_update_data  (dr_update_data),
    .dr_update_valid (dr_update_valid),
    .tap_state       (tap_state)
  );

  int checks = 0, failures = 0;

  typedef struct packed { bit care; bit val; } tdo_exp_t;
  tdo_exp_t    tdo_q[$];
  logic [31:0] upd_q[$];
  tdo_exp_t    mon_e;

  // Reference model state
  bit [3:0]  m_state;
  bit [4:0]  m_ir, m_ir_sr;
  bit [31:0] m_dr;
  bit        m_tdo_known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(1));
  endfunction

  function automatic bit is_user(input bit [4:0] ir);
    return UserEn && ir == 5'h10;
  endfunction

  function automatic int dr_len(input bit [4:0] ir);
    return (ir == 5'h01 || is_user(ir)) ? 32 : 1;
  endfunction

  function automatic bit [3:0] next_state(input bit [3:0] s, input bit t);
    bit [7:0] e;
    e = NEXT[s];
    return t ? e[7:4] : e[3:0];
  endfunction

  task automatic model_reset();
    m_state = 4'hF; m_ir = 5'h01; m_ir_sr = '0; m_dr = '0; m_tdo_known = 1'b1;
  endtask

  task automatic model_rise(input bit t_ms, input bit t_di);
    int n;
    case (m_state)
      4'hE: m_ir_sr = 5'h01;
      4'hA: m_ir_sr = {t_di, m_ir_sr[4:1]};
      4'h6: m_dr = (m_ir == 5'h01) ? IDCODE : (is_user(m_ir) ? dr_capture_data : 32'h0);
      4'h2: begin
        n = dr_len(m_ir);
        m_dr = m_dr >> 1;
        m_dr[n-1] = t_di;
      end
      default: ;
    endcase
    m_state = next_state(m_state, t_ms);
    if (m_state == 4'hF) m_ir = 5'h01;
  endtask

  task automatic model_fall();
    if (m_state == 4'hD) m_ir = m_ir_sr;
    if (m_state == 4'h5 && is_user(m_ir)) upd_q.push_back(m_dr);
    m_tdo_known = 1'b1;
  endtask

  task automatic tck_cycle(input bit t_ms, input bit t_di);
    tdo_exp_t e;
    @(negedge clk);
    tms = t_ms;
    tdi = t_di;
    repeat (PH) @(negedge clk);
    check("tap_state", 32'(tap_state), 32'(m_state));
    e.care = m_tdo_known;
    e.val  = (m_state == 4'hA) ? m_ir_sr[0] : ((m_state == 4'h2) ? m_dr[0] : 1'b0);
    tdo_q.push_back(e);
    tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (PH) @(negedge clk);
    tck = 1'b0;
    model_fall();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_tap_state", 32'(tap_state), 32'hF);
    check("reset_tdo", 32'(tdo), 32'h0);
    check("reset_update_valid", 32'(dr_update_valid), 32'h0);
    check("reset_update_data", dr_update_data, 32'h0);
  endtask

  task automatic trst_pulse();
    @(negedge clk);
    trstn = 1'b0;
    repeat (4) @(negedge clk);
    trstn = 1'b1;
    m_state = 4'hF; m_ir = 5'h01; m_tdo_known = 1'b0;
    repeat (4) @(negedge clk);
    check("trstn_tap_state", 32'(tap_state), 32'hF);
  endtask

  task automatic to_rti();
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, rb());
    check("tms_idle_tlr", 32'(tap_state), 32'hF);
    tck_cycle(1'b0, rb());
  endtask

  // Both shift tasks start and end in Run-Test/Idle.
  task automatic shift_ir(input bit [4:0] v);
    tck_cycle(1'b1, rb()); tck_cycle(1'b1, rb()); tck_cycle(1'b0, rb()); tck_cycle(1'b0, rb());
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i]);
    tck_cycle(1'b1, rb()); tck_cycle(1'b0, rb());
  endtask

  task automatic shift_dr(input int n, input logic [63:0] d);
    tck_cycle(1'b1, rb()); tck_cycle(1'b0, rb()); tck_cycle(1'b0, rb());
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, d[i]);
    tck_cycle(1'b1, rb()); tck_cycle(1'b0, rb());
  endtask

  always @(posedge tck) begin
    if (tdo_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL tdo_scoreboard: tck rise with no expectation, tdo=%b", tdo);
    end else begin
      mon_e = tdo_q.pop_front();
      if (mon_e.care) check("tdo", 32'(tdo), 32'(mon_e.val));
    end
  end

  always @(negedge clk) begin
    if (!rst && dr_update_valid === 1'b1) begin
      if (upd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL dr_update_valid: unexpected pulse data=%h expected none", dr_update_data);
      end else begin
        check("dr_update_data", dr_update_data, upd_q.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // IDCODE read from TLR
    tck_cycle(1'b0, 1'b0);
    shift_dr(32, 64'($urandom));

    // IR capture pattern, then BYPASS
    shift_ir(5'h1F);
    shift_dr(8, 64'hA5);

    // User DR (BYPASS when the feature is compiled out)
    shift_ir(5'h10);
    dr_capture_data = 32'hCAFE_BABE;
    shift_dr(32, 64'h1234_5678);

    // TLR via TMS from Pause-DR with a non-IDCODE instruction loaded
    shift_ir(5'h1F);
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, rb());
    tck_cycle(1'b1, 1'b1); tck_cycle(1'b0, 1'b0);
    check("pause_dr_state", 32'(tap_state), 32'h3);
    to_rti();
    shift_dr(32, 64'($urandom));

    // trstn mid-shift of the user DR
    shift_ir(5'h10);
    dr_capture_data = $urandom;
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, rb());
    trst_pulse();
    tck_cycle(1'b0, 1'b0);
    shift_dr(32, 64'($urandom));

    // rst mid-shift of the user DR
    shift_ir(5'h10);
    tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck_cycle(1'b0, rb());
    do_reset();
    tck_cycle(1'b0, 1'b0);

    // Randomized instruction/data traffic
    for (int it = 0; it < 10; it++) begin
      bit [4:0] ir;
      case ($urandom_range(3))
        0: ir = 5'h01;
        1: ir = 5'h1F;
        2: ir = 5'h10;
        default: ir = 5'($urandom);
      endcase
      dr_capture_data = $urandom;
      shift_ir(ir);
      shift_dr($urandom_range(40, 1), {32'($urandom), 32'($urandom)});
      for (int k = 0; k < 20; k++) begin
        dr_capture_data = $urandom;
        tck_cycle($urandom_range(2) == 0, rb());
        if ($urandom_range(60) == 0) trst_pulse();
      end
      to_rti();
    end

    repeat (10) @(negedge clk);
    check("tdo_queue_drained", 32'(tdo_q.size()), 32'h0);
    check("update_queue_drained", 32'(upd_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
